load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// RV32 load/store unit: one outstanding access, byte-lane steering on the way out,
// load formatting on the way back, with an access-fault check and a memory timeout.
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic [CW-1:0]           cnt_r;
    logic                    we_r;
    logic [2:0]              funct3_r;
    logic [1:0]              addr_lo_r;
    logic                    accept_s;
    logic                    timeout_s;
    logic                    rsp_err_s;
    logic [DATA_WIDTH-1:0]   rsp_rdata_s;

    function automatic logic is_fault(input logic we, input logic [2:0] f3, input logic [1:0] a);
        logic flt_s;
        if (we) begin
            flt_s = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
        end else begin
            flt_s = (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
        end
        case (f3[1:0])
            2'b01:   flt_s = flt_s | a[0];
            2'b10:   flt_s = flt_s | (a != 2'b00);
            default: flt_s = flt_s;
        endcase
        return flt_s;
    endfunction

    function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] steer_wdata(input logic [2:0] f3, input logic [DATA_WIDTH-1:0] w);
        case (f3[1:0])
            2'b00:   return {4{w[7:0]}};
            2'b01:   return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] format_load(input logic [2:0] f3, input logic [1:0] a,
                                                          input logic [DATA_WIDTH-1:0] raw);
        logic [DATA_WIDTH-1:0] shift_s;
        logic [7:0]            byte_s;
        logic [15:0]           half_s;
        shift_s = raw >> {a, 3'b000};
        byte_s  = shift_s[7:0];
        half_s  = a[1] ? raw[31:16] : raw[15:0];
        case (f3)
            3'b000:  return {{24{byte_s[7]}}, byte_s};
            3'b100:  return {24'h000000, byte_s};
            3'b001:  return {{16{half_s[15]}}, half_s};
            3'b101:  return {16'h0000, half_s};
            3'b010:  return raw;
            default: return {DATA_WIDTH{1'b0}};
        endcase
    endfunction

    assign accept_s  = req_valid & req_ready;
    assign timeout_s = (cnt_r == TO_LAST);

    // Next state and the response that goes with entering RESP; timeout loses to rvalid
    always_comb begin
        state_s     = state_r;
        rsp_err_s   = 1'b0;
        rsp_rdata_s = {DATA_WIDTH{1'b0}};
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (is_fault(req_we, req_funct3, req_addr[1:0])) begin
                        state_s   = RESP;
                        rsp_err_s = 1'b1;
                    end else begin
                        state_s = REQ;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                if (timeout_s) begin
                    state_s   = RESP;
                    rsp_err_s = 1'b1;
                end else if (mem_gnt) begin
                    state_s = WAIT;
                end else begin
                    state_s = REQ;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_s     = RESP;
                    rsp_rdata_s = we_r ? {DATA_WIDTH{1'b0}} : format_load(funct3_r, addr_lo_r, mem_rdata);
                end else if (timeout_s) begin
                    state_s   = RESP;
                    rsp_err_s = 1'b1;
                end else begin
                    state_s = WAIT;
                end
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM state, timeout counter and captured request attributes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= {CW{1'b0}};
            we_r      <= 1'b0;
            funct3_r  <= 3'b000;
            addr_lo_r <= 2'b00;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                cnt_r     <= {CW{1'b0}};
                we_r      <= req_we;
                funct3_r  <= req_funct3;
                addr_lo_r <= req_addr[1:0];
            end else if (state_r == REQ || state_r == WAIT) begin
                cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Registered handshake and response outputs, derived from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= {DATA_WIDTH{1'b0}};
            mem_req   <= 1'b0;
        end else begin
            req_ready <= (state_s == IDLE);
            rsp_valid <= (state_s == RESP);
            rsp_err   <= rsp_err_s;
            rsp_rdata <= rsp_rdata_s;
            mem_req   <= (state_s == REQ);
        end
    end

    // Memory command fields are captured once at accept and held through the grant wait
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= {ADDR_WIDTH{1'b0}};
            mem_be    <= 4'b0000;
            mem_wdata <= {DATA_WIDTH{1'b0}};
        end else if (state_r == IDLE && state_s == REQ) begin
            mem_we    <= req_we;
            mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_be    <= byte_enable(req_funct3, req_addr[1:0]);
            mem_wdata <= steer_wdata(req_funct3, req_wdata);
        end else begin
            mem_we    <= mem_we;
            mem_addr  <= mem_addr;
            mem_be    <= mem_be;
            mem_wdata <= mem_wdata;
        end
    end

endmodule
